// File: rtl/gate_response_checker.sv
// Built-in test controller for the 3-input basic-gate block: sweeps all eight
// {a,b,c} vectors, compares y against golden values and records failures.
module gate_response_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic [6:0] y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail_vec,
  output logic [6:0] first_fail_bits
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
  localparam logic [3:0] ERR_MAX     = 4'd8;

  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic [2:0] ffv_q, ffv_d;
  logic [6:0] ffb_q, ffb_d;

  logic [6:0] golden;
  logic [6:0] diff;
  logic       mismatch;
  logic       andV, orV, xorV;

  // Golden bit order follows y: bit 0 is y1, bit 6 is y7.
  always_comb begin
    andV     = &vec_q;
    orV      = |vec_q;
    xorV     = ^vec_q;
    golden   = {~vec_q[2], ~xorV, xorV, ~orV, ~andV, orV, andV};
    diff     = y ^ golden;
    mismatch = |diff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= 8'd0;
      err_q   <= 4'd0;
      ffv_q   <= 3'd0;
      ffb_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffb_q   <= ffb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffb_d   = ffb_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_d   = 3'd0;
          cnt_d   = SETTLE_LOAD;
          err_d   = 4'd0;
          ffv_d   = 3'd0;
          ffb_d   = 7'd0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) state_d = CHECK;
      end
      CHECK: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + 4'd1;
          // A zero count means no failure has been seen since start.
          if (err_q == 4'd0) begin
            ffv_d = vec_q;
            ffb_d = diff;
          end
        end
        if (vec_q == 3'd7) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 3'd1;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign {a, b, c}       = vec_q;
  assign busy            = (state_q == SETTLE) || (state_q == CHECK);
  assign done            = (state_q == DONE);
  assign pass            = done && (err_q == 4'd0);
  assign err_count       = err_q;
  assign first_fail_vec  = ffv_q;
  assign first_fail_bits = ffb_q;

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
- Synthesizable self-checking driver and response analyser for the 3-input basic-gate block (inputs a, b, c; outputs y1..y7).
- Sweeps all eight {a,b,c} vectors in ascending order and waits a settle interval after each.
- Samples the gate outputs, compares them against internally computed golden values, and accumulates a mismatch count plus first-failure data.
- Sits beside the gate block on-chip as its built-in test controller. It is the hardware counterpart to the simulation stimulus bench.

Parameters:
- SETTLE_CYCLES, 2, clock cycles the vector is held before the outputs are sampled; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a sweep; sampled only in IDLE or DONE.
- a  output  1  stimulus bit 2 of the vector (MSB).
- b  output  1  stimulus bit 1 of the vector.
- c  output  1  stimulus bit 0 of the vector (LSB).
- y  input  7  gate outputs; y[0]=y1 … y[6]=y7.
- busy  output  1  high while in SETTLE or CHECK.
- done  output  1  high in DONE; held until the next start or rst.
- pass  output  1  equals done AND (err_count==0).
- err_count  output  4  number of vectors with any mismatch, 0..8.
- first_fail_vec  output  3  {a,b,c} of the first failing vector.
- first_fail_bits  output  7  y XOR expected, captured at the first failing vector.

Behaviour:
- Reset values: state IDLE; {a,b,c}=000; busy=0; done=0; pass=0; err_count=0; first_fail_vec=0; first_fail_bits=0. Settle counter and vector register are also cleared.
- rst has priority over every other event. Asserting rst mid-sweep aborts the sweep; all outputs reach reset values at the same edge.
- Golden values for vector v={a,b,c}:
  - y1=a&b&c
  - y2=a|b|c
  - y3=~(a&b&c)
  - y4=~(a|b|c)
  - y5=a^b^c
  - y6=~(a^b^c)
  - y7=~a
- IDLE:
  - start=1 at edge k → {a,b,c}<=000.
  - Also at edge k: err_count, first_fail_* and done are cleared, the settle counter is loaded with SETTLE_CYCLES, and the state moves to SETTLE.
- SETTLE:
  - The counter decrements each cycle.
  - After SETTLE_CYCLES cycles in SETTLE, the state moves to CHECK. The vector on a,b,c is stable throughout.
- CHECK (exactly one cycle):
  - The y sampled in this cycle is compared with golden(v).
  - On any mismatch, err_count increments; it saturates at 8, which cannot be exceeded.
  - If this is the first mismatch since start, first_fail_vec<=v and first_fail_bits<=y^golden(v).
  - If v==7, the state moves to DONE. Otherwise v<=v+1, the counter reloads, and the state moves to SETTLE.
  - The vector never wraps within a sweep.
- DONE:
  - done=1 and pass valid. a,b,c hold 111, and results hold.
  - start=1 behaves exactly as start in IDLE: results are cleared and a new sweep begins at 000.
- Timing: with S=SETTLE_CYCLES, each vector occupies S+1 cycles.
  - busy rises at edge k.
  - done rises at edge k+8(S+1); with the default S=2, that is k+24.
- start while busy is ignored and has no effect on the vector, counter or results.
- start held high continuously causes back-to-back sweeps. Each DONE lasts one cycle before the restart.
- y is treated as synchronous to clk; the block adds no synchronizer.

Test Plan:
- Fault-free model, S=2, start pulse at edge k:
  - a,b,c step through 000..111, each held 3 cycles.
  - done=1 at edge k+24, pass=1, err_count=0, first_fail_vec=0, first_fail_bits=0.
- y5 stuck at 0:
  - Mismatches on 001, 010, 100, 111.
  - err_count=4, pass=0, first_fail_vec=001, first_fail_bits=7'b0010000.
- y7 inverted (y7=a):
  - All 8 vectors fail; err_count=8 (saturated), first_fail_vec=000, first_fail_bits=7'b1000000.
- rst asserted on the CHECK cycle of vector 011:
  - Next edge: state IDLE, busy=0, {a,b,c}=000, err_count=0.
  - A subsequent start completes a full fresh sweep.
- start pulsed while busy at vector 010:
  - Sweep timing unchanged; done still at k+24.
- After a failing sweep, start again with a fault-free model:
  - err_count and first_fail_* clear at the start edge.
  - Ends with pass=1.
